riscv_dmi_initiator: RTL

- Memory-mapped DMI initiator. It is the requester end of the DMI req/resp handshake that riscv_dm serves.
- Purpose: lets an on-chip host (boot controller, management core) drive the Debug Module without JTAG.
- Host side: an SRI-style register window with 1-cycle read latency. DMI side: connects directly to the riscv_dm req_*/resp_* ports in the same clock domain.

---
 rtl/riscv_dmi_initiator.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_dmi_initiator.sv
// Memory-mapped DMI requester: an SRI register window that issues riscv_dm req/resp transactions.
// Optional busy-response retry is enabled with `define RISCV_DMI_BUSY_RETRY_EN.
module riscv_dmi_initiator #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int MAX_RETRIES    = 4,
    parameter int DMI_ADDR_WIDTH = 7,
    parameter int DMI_DATA_WIDTH = 32,
    parameter int DMI_OP_WIDTH   = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [ADDR_WIDTH-1:0]     sri_addr_i,
    input  logic                      sri_en_i,
    input  logic                      sri_we_i,
    input  logic [DATA_WIDTH-1:0]     sri_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   sri_be_i,
    output logic [DATA_WIDTH-1:0]     sri_rdata_o,
    output logic                      sri_error_o,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output logic [DMI_ADDR_WIDTH-1:0] req_addr_o,
    output logic [DMI_DATA_WIDTH-1:0] req_data_o,
    output logic [DMI_OP_WIDTH-1:0]   req_op_o,
    input  logic                      resp_valid_i,
    output logic                      resp_ready_o,
    input  logic [DMI_DATA_WIDTH-1:0] resp_data_i,
    input  logic [DMI_OP_WIDTH-1:0]   resp_op_i,
    output logic                      busy_o
);

    localparam logic [DMI_OP_WIDTH-1:0] OP_OK   = '0;
    localparam logic [DMI_OP_WIDTH-1:0] OP_RD   = DMI_OP_WIDTH'(1);
    localparam logic [DMI_OP_WIDTH-1:0] OP_WR   = DMI_OP_WIDTH'(2);
`ifdef RISCV_DMI_BUSY_RETRY_EN
    localparam logic [DMI_OP_WIDTH-1:0] OP_BUSY = DMI_OP_WIDTH'(3);
`else
    localparam int unused_max_retries = MAX_RETRIES;
`endif

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                    state_q, state_d;
    logic [DMI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DMI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DMI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DMI_OP_WIDTH-1:0]   last_op_q, last_op_d;
    logic                      err_q, err_d;
    logic [7:0]                retry_q, retry_d;
    logic [DMI_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DMI_DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [DMI_OP_WIDTH-1:0]   req_op_q, req_op_d;
    logic [DATA_WIDTH-1:0]     sri_rdata_q, sri_rdata_d;
    logic                      sri_error_q, sri_error_d;

    logic                      busy;
    logic [2:0]                idx;
    logic [DATA_WIDTH-1:0]     status;
    logic                      launch, set_err, clr_err;
    logic                      unused_bits;

    assign unused_bits = ^{sri_addr_i[ADDR_WIDTH-1:6], sri_addr_i[2:0],
                           sri_wdata_i[DATA_WIDTH-1:DMI_DATA_WIDTH],
                           sri_be_i[DATA_WIDTH/8-1:DMI_DATA_WIDTH/8]};

    assign busy   = (state_q != IDLE);
    assign idx    = sri_addr_i[5:3];
    assign status = {{(DATA_WIDTH-16){1'b0}}, retry_q, 4'b0, err_q, last_op_q, busy};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        last_op_d   = last_op_q;
        err_d       = err_q;
        retry_d     = retry_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;
        sri_rdata_d = sri_rdata_q;
        sri_error_d = 1'b0;
        launch      = 1'b0;
        set_err     = 1'b0;
        clr_err     = 1'b0;

        if (sri_en_i) begin
            if (!sri_we_i) begin
                sri_error_d = idx[2];
                case (idx)
                    3'd0:    sri_rdata_d = {{(DATA_WIDTH-DMI_ADDR_WIDTH){1'b0}}, addr_q};
                    3'd1:    sri_rdata_d = {{(DATA_WIDTH-DMI_DATA_WIDTH){1'b0}}, rdata_q};
                    3'd2:    sri_rdata_d = status;
                    default: sri_rdata_d = '0;
                endcase
            end else if (idx[2] || (busy && idx != 3'd3)) begin
                // Writes that would disturb an in-flight request are dropped.
                sri_error_d = 1'b1;
            end else begin
                case (idx)
                    3'd0: if (sri_be_i[0]) addr_d = sri_wdata_i[DMI_ADDR_WIDTH-1:0];
                    3'd1: begin
                        for (int b = 0; b < DMI_DATA_WIDTH/8; b++) begin
                            if (sri_be_i[b]) wdata_d[8*b +: 8] = sri_wdata_i[8*b +: 8];
                        end
                    end
                    3'd2: begin
                        if (sri_be_i[0]) begin
                            if (sri_wdata_i[1:0] == OP_RD || sri_wdata_i[1:0] == OP_WR) launch = 1'b1;
                            else sri_error_d = 1'b1;
                        end
                    end
                    default: clr_err = 1'b1;
                endcase
            end
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d    = REQ;
                    req_addr_d = addr_q;
                    req_data_d = wdata_q;
                    req_op_d   = sri_wdata_i[DMI_OP_WIDTH-1:0];
                    retry_d    = '0;
                end
            end
            REQ: begin
                if (req_ready_i) state_d = RESP;
            end
            RESP: begin
                if (resp_valid_i) begin
                    last_op_d = resp_op_i;
                    if (req_op_q == OP_RD && resp_op_i == OP_OK) rdata_d = resp_data_i;
                    state_d = IDLE;
`ifdef RISCV_DMI_BUSY_RETRY_EN
                    if (resp_op_i == OP_BUSY && retry_q < 8'(MAX_RETRIES)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = REQ;
                    end else begin
                        set_err = (resp_op_i != OP_OK);
                    end
`else
                    set_err = (resp_op_i != OP_OK);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A simultaneous clear loses against a new error.
        if (clr_err) err_d = 1'b0;
        if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            last_op_q   <= '0;
            err_q       <= 1'b0;
            retry_q     <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
            sri_rdata_q <= '0;
            sri_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            last_op_q   <= last_op_d;
            err_q       <= err_d;
            retry_q     <= retry_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
            sri_rdata_q <= sri_rdata_d;
            sri_error_q <= sri_error_d;
        end
    end

    assign sri_rdata_o  = sri_rdata_q;
    assign sri_error_o  = sri_error_q;
    assign req_valid_o  = (state_q == REQ);
    assign resp_ready_o = (state_q == RESP);
    assign req_addr_o   = req_addr_q;
    assign req_data_o   = req_data_q;
    assign req_op_o     = req_op_q;
    assign busy_o       = busy;

endmodule
